// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR pair plus a three-state access sequencer.
// The CPU loads MAR/MDR from Bus and issues Req. The sequencer then drives the
// RAM strobes until Mem_Ready and reports completion with a one-cycle Done.
// Optional feature macro: MAU_TIMEOUT_EN. When it is defined, an access that
// waits TIMEOUT_CYC cycles without Mem_Ready is aborted and completes with Err=1.
//
// Handshake: Req is a level sampled only in IDLE. Sampling it starts one
// access. Busy stays high from the cycle after Req until Done has been seen.
// Done is exactly one cycle long. Err is meaningful only while Done=1.
// Mem_Ready is sampled only while Mem_CE=1, and its first high sample ends the
// access.
module mem_access_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Bus,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              Req,
  input  logic              WE,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] MAR_Out,
  output logic [DATA_W-1:0] MDR_Out,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Mem_CE,
  output logic              Mem_WE,
  input  logic              Mem_Ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              wr_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              to_hit;

  // A zero timeout would make every access abort before the RAM is ever sampled.
  if (TIMEOUT_CYC < 1) begin : g_timeout_range_check
    $error("mem_access_unit: TIMEOUT_CYC must be at least 1");
  end

`ifdef MAU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // This is the last ACCESS cycle allowed. Mem_Ready in the same cycle still
  // counts as a normal completion, because the terminal count is gated by !Mem_Ready.
  assign to_hit = (state_q == ACCESS) && !Mem_Ready &&
                  (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Wait counter. It is held at zero outside an access, so it starts clean on entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (state_q != ACCESS) begin
      cnt_q <= '0;
    end else if (!Mem_Ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Remembers whether the access that ended was an abort. It is cleared in IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      err_q <= to_hit;
    end else if (state_q == IDLE) begin
      err_q <= 1'b0;
    end
  end

  assign Err = (state_q == DONE) && err_q;
`else
  assign to_hit = 1'b0;
  assign Err    = 1'b0;
`endif

  // State register, access-type latch, and the MAR/MDR datapath.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        // CPU loads are accepted only here, so MAR/MDR stay frozen during an access.
        if (LD_MAR) mar_q <= Bus[ADDR_W-1:0];
        if (LD_MDR) mdr_q <= Bus;
        if (Req)    wr_q  <= WE;
      end else if (state_q == ACCESS && Mem_Ready && !wr_q) begin
        mdr_q <= Mem_RData;
      end
    end
  end

  // Next-state logic. The timeout path only ever fires when the macro is enabled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Req) state_d = ACCESS;
      ACCESS:  if (Mem_Ready || to_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);
  assign Mem_CE    = (state_q == ACCESS);
  assign Mem_WE    = (state_q == ACCESS) && wr_q;
  assign MAR_Out   = mar_q;
  assign MDR_Out   = mdr_q;
  assign Mem_Addr  = mar_q;
  assign Mem_WData = mdr_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W  16  data and MDR width
  ADDR_W  16  address and MAR width
  TIMEOUT_CYC  15  ACCESS cycles before abort; only used with MAU_TIMEOUT_EN
REQ-002 Ports SHALL be, one per line:
  Clk  in  1  sole clock; all state updates on rising edge
  Reset  in  1  synchronous, active-high
  Bus  in  DATA_W  CPU bus; source for MAR/MDR loads
  LD_MAR  in  1  load MAR from Bus[ADDR_W-1:0]
  LD_MDR  in  1  load MDR from Bus
  Req  in  1  start a memory access
  WE  in  1  access type, sampled with Req: 1=write, 0=read
  Busy  out  1  access in progress
  Done  out  1  one-cycle completion pulse
  Err  out  1  completion was a timeout abort; valid only while Done=1
  MAR_Out  out  ADDR_W  current MAR
  MDR_Out  out  DATA_W  current MDR
  Mem_Addr  out  ADDR_W  RAM address, always equals MAR
  Mem_WData  out  DATA_W  RAM write data, always equals MDR
  Mem_RData  in  DATA_W  RAM read data
  Mem_CE  out  1  RAM chip enable
  Mem_WE  out  1  RAM write enable
  Mem_Ready  in  1  RAM completes the current access
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-005 IDLE with Req=1 SHALL go to ACCESS and latch WE into wr_q; with Req=0 it SHALL stay in IDLE.
REQ-006 ACCESS with Mem_Ready=1 SHALL go to DONE; on a read (wr_q=0) it SHALL load MDR from Mem_RData on the same edge.
REQ-007 ACCESS with Mem_Ready=0 SHALL remain in ACCESS; the wait has no bound except as set by REQ-016.
REQ-008 DONE SHALL return to IDLE unconditionally after one cycle; Req in DONE SHALL be ignored.
REQ-009 Outputs SHALL be decoded from state: Mem_CE=(ACCESS); Mem_WE=(ACCESS & wr_q); Busy=(state!=IDLE); Done=(DONE).
REQ-010 Latency: Req sampled at edge N SHALL give Mem_CE=1 in cycle N+1; Done SHALL assert one cycle after the first Mem_Ready=1 seen in ACCESS. The minimum is Done in cycle N+2.
REQ-011 LD_MAR and LD_MDR SHALL take effect only in IDLE; in ACCESS and DONE they SHALL be ignored, so MAR and MDR are stable for the whole access.
REQ-012 LD_MAR and Req in the same IDLE cycle SHALL load MAR and start the access, and the access SHALL use the newly loaded address.
REQ-013 LD_MDR=1 and a Mem_RData capture SHALL never occur on the same edge, because of REQ-011. A write SHALL leave MDR unchanged.
REQ-014 Address and data widths SHALL follow ADDR_W and DATA_W with no truncation inside the block; only Bus to MAR narrows, taking the low ADDR_W bits.

Reset
REQ-015 Reset=1 at any edge, including mid-ACCESS, SHALL force:
  - state=IDLE, wr_q=0
  - MAR=0, MDR=0, timeout counter=0
  - from the next cycle: Busy=0, Done=0, Err=0, Mem_CE=0, Mem_WE=0
  An interrupted access SHALL NOT produce Done.

Configuration
REQ-016 Macro MAU_TIMEOUT_EN, when defined:
  - a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with Mem_Ready=0.
  - on reaching TIMEOUT_CYC, the FSM SHALL go to DONE with Err=1 for that DONE cycle and leave MDR unchanged.
  - Mem_Ready=1 in the same cycle as the terminal count SHALL win, giving a normal completion with Err=0.
REQ-017 Macro MAU_TIMEOUT_EN, when undefined: no counter SHALL be built, Err SHALL be tied to 0, and ACCESS SHALL wait indefinitely.

Verification
REQ-018 Read: Bus=16'h3000 with LD_MAR and Req, WE=0; Mem_Ready=1 in first ACCESS cycle with Mem_RData=16'hBEEF -> Mem_Addr=16'h3000, Mem_CE=1 and Mem_WE=0 for one cycle, Done two cycles after Req, MDR_Out=16'hBEEF.
REQ-019 Write: LD_MDR Bus=16'h1234, then Req with WE=1; Mem_Ready held low for 3 cycles -> Mem_WE=1 for 4 cycles, Mem_WData=16'h1234 throughout, single Done pulse, MDR unchanged.
REQ-020 Loads during access: LD_MAR Bus=16'h00FF pulsed while in ACCESS -> MAR_Out stays at the original address until back in IDLE.
REQ-021 Reset mid-ACCESS: assert Reset in the second ACCESS cycle -> next cycle Busy=0, Mem_CE=0, MAR_Out=0, MDR_Out=0, and no Done.
REQ-022 Timeout (MAU_TIMEOUT_EN defined, TIMEOUT_CYC=15): Mem_Ready stuck at 0 -> Done=1 and Err=1 after 15 ACCESS cycles, MDR unchanged.
REQ-023 Timeout tie case: Mem_Ready=1 exactly on the terminal count -> Err=0 and MDR captured.
REQ-024 Timeout absent (MAU_TIMEOUT_EN undefined): Mem_Ready stuck at 0 for 100 cycles -> Busy stays 1 and Err stays 0.
